// File: rtl/ctr_seq_pkg.sv
// Shared types and constants for the ctr_seq measurement sequencer.
// State encoding, result-file slots and default parameters.
package ctr_seq_pkg;

  localparam int CAL_DEF  = 6;
  localparam int GW_DEF   = 16;
  localparam int RD_WORDS = 6;

  typedef enum logic [3:0] {
    S_IDLE,
    S_C0,
    S_C0R,
    S_C1,
    S_C1R,
    S_ARM,
    S_GATE,
    S_STOP,
    S_READ,
    S_FIN
  } state_t;

  localparam logic [2:0] IDX_C0 = 3'd0;
  localparam logic [2:0] IDX_C1 = 3'd1;
  localparam logic [2:0] IDX_X0 = 3'd2;
  localparam logic [2:0] IDX_X1 = 3'd3;
  localparam logic [2:0] IDX_X2 = 3'd4;
  localparam logic [2:0] IDX_X3 = 3'd5;
  localparam logic [2:0] IDX_R0 = 3'd6;
  localparam logic [2:0] IDX_R1 = 3'd7;

endpackage

// File: rtl/ctr_seq_sync2.sv
// Two-flop synchroniser for the counter handshake acknowledges.
// Both flops clear on reset.
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic m;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m <= 1'b0;
      q <= 1'b0;
    end else begin
      m <= d;
      q <= m;
    end
  end

endmodule

// File: rtl/ctr_seq.sv
// Measurement sequencer: calibrates, gates and reads back an
// external counter, storing eight result words in a local file.
module ctr_seq
  import ctr_seq_pkg::*;
#(
  parameter int SIZE = 8,
  parameter int GW   = GW_DEF,
  parameter int CAL  = CAL_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      bsel,
  input  logic [1:0]      esel,
  input  logic [GW-1:0]   gate,
  input  logic [GW-1:0]   tmo,
  output logic            busy,
  output logic            done,
  output logic            err,
  input  logic [2:0]      rsel,
  output logic [SIZE-1:0] rdat,
  output logic            crs,
  output logic [1:0]      bis,
  output logic [1:0]      eis,
  output logic            brq,
  output logic            erq,
  output logic            ip0,
  output logic            ip1,
  output logic [1:0]      xis,
  output logic            ris,
  input  logic            bac,
  input  logic            eac,
  input  logic [SIZE-1:0] cnx,
  input  logic [SIZE-1:0] cnr
);

  state_t          state;
  state_t          nstate;
  logic [GW-1:0]   cnt;
  logic [GW-1:0]   wcnt;
  logic [GW-1:0]   wnxt;
  logic [GW-1:0]   glen;
  logic [1:0]      bsl;
  logic [1:0]      esl;
  logic            bac_s;
  logic            eac_s;
  logic            tmo_hit;
  logic [2:0]      word;
  logic [SIZE-1:0] res [8];

  sync2 u_bac (
    .clk (clk),
    .rst (rst),
    .d   (bac),
    .q   (bac_s)
  );

  sync2 u_eac (
    .clk (clk),
    .rst (rst),
    .d   (eac),
    .q   (eac_s)
  );

  assign wnxt    = (&wcnt) ? wcnt : wcnt + GW'(1);
  assign tmo_hit = (tmo != '0) && (wnxt == tmo);
  assign glen    = (gate == '0) ? GW'(1) : gate;
  assign word    = cnt[3:1];
  assign rdat    = res[rsel];

  always_comb begin
    nstate = state;
    case (state)
      S_IDLE: if (start) nstate = S_C0;
      S_C0:   if (cnt == GW'(CAL-1)) nstate = S_C0R;
      S_C0R:  if (cnt == GW'(1)) nstate = S_C1;
      S_C1:   if (cnt == GW'(CAL-1)) nstate = S_C1R;
      S_C1R:  if (cnt == GW'(1)) nstate = S_ARM;
      S_ARM: begin
        if (bac_s)        nstate = S_GATE;
        else if (tmo_hit) nstate = S_FIN;
      end
      S_GATE: if (cnt == glen - GW'(1)) nstate = S_STOP;
      S_STOP: begin
        if (eac_s)        nstate = S_READ;
        else if (tmo_hit) nstate = S_FIN;
      end
      S_READ: begin
        if (cnt == GW'(2*RD_WORDS-1)) nstate = S_FIN;
      end
      S_FIN:   nstate = S_IDLE;
      default: nstate = S_IDLE;
    endcase
  end

  always_comb begin
    crs  = 1'b0;
    ip0  = 1'b0;
    ip1  = 1'b0;
    brq  = 1'b0;
    erq  = 1'b0;
    bis  = 2'b00;
    eis  = 2'b00;
    xis  = 2'b00;
    ris  = 1'b0;
    busy = 1'b1;
    done = 1'b0;
    case (state)
      S_IDLE: begin
        crs  = 1'b1;
        busy = 1'b0;
      end
      S_C0:  ip0 = 1'b1;
      // second cycle of the capture slot resets the counter
      S_C0R: crs = cnt[0];
      S_C1:  ip1 = 1'b1;
      S_C1R: crs = cnt[0];
      S_ARM, S_GATE: begin
        brq = 1'b1;
        bis = bsl;
        eis = esl;
      end
      S_STOP: begin
        brq = 1'b1;
        erq = 1'b1;
        bis = bsl;
        eis = esl;
      end
      S_READ: begin
        brq = 1'b1;
        erq = 1'b1;
        bis = bsl;
        eis = esl;
        if (word < 3'd4) xis = word[1:0];
        ris = (word == 3'd5);
      end
      S_FIN: begin
        crs  = 1'b1;
        busy = 1'b0;
        done = 1'b1;
      end
      default: begin
        crs  = 1'b1;
        busy = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      wcnt  <= '0;
      bsl   <= 2'b00;
      esl   <= 2'b00;
      err   <= 1'b0;
    end else begin
      state <= nstate;
      cnt   <= (nstate != state) ? '0 : cnt + GW'(1);
      wcnt  <= (nstate != state) ? '0 : wnxt;
      if (state == S_IDLE && start) begin
        bsl <= bsel;
        esl <= esel;
        err <= 1'b0;
      end
      // FIN is only reachable from a wait state by timing out
      if (nstate == S_FIN &&
          (state == S_ARM || state == S_STOP))
        err <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 8; i++) res[i] <= '0;
    end else begin
      if (state == S_C0R && cnt == '0) res[IDX_C0] <= cnx;
      if (state == S_C1R && cnt == '0) res[IDX_C1] <= cnx;
      if (state == S_READ && cnt[0])
        res[IDX_X0 + word] <= (word < 3'd4) ? cnx : cnr;
    end
  end

endmodule

// File: tb/tb_ctr_seq.sv
// Randomized directed bench for ctr_seq with a timeline and
// result-file reference model.
module tb_ctr_seq;

  localparam int SIZE = 8;
  localparam int GW   = 16;
  localparam int CAL  = 6;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [1:0]      bsel, esel;
  logic [GW-1:0]   gate, tmo;
  logic            busy, done, err;
  logic [2:0]      rsel;
  logic [SIZE-1:0] rdat;
  logic            crs, brq, erq, ip0, ip1, ris;
  logic [1:0]      bis, eis, xis;
  logic            bac, eac;
  logic [SIZE-1:0] cnx, cnr;
  logic [SIZE-1:0] xoff, roff;

  int nvec = 0;
  int nerr = 0;
  int done_cnt = 0;
  logic [SIZE-1:0] mres [8];
  logic [1:0] bs, es;

  always #5 clk = ~clk;

  assign cnx = xoff + SIZE'(xis);
  assign cnr = roff + SIZE'(ris);

  always @(posedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

  ctr_seq #(.SIZE(SIZE), .GW(GW), .CAL(CAL)) dut (
    .clk(clk), .rst(rst), .start(start),
    .bsel(bsel), .esel(esel), .gate(gate), .tmo(tmo),
    .busy(busy), .done(done), .err(err),
    .rsel(rsel), .rdat(rdat),
    .crs(crs), .bis(bis), .eis(eis),
    .brq(brq), .erq(erq), .ip0(ip0), .ip1(ip1),
    .xis(xis), .ris(ris), .bac(bac), .eac(eac),
    .cnx(cnx), .cnr(cnr)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // expected pin values n cycles after the accepting edge
  task automatic timeline(input int n, input int g);
    int fin, stp, rd, w;
    fin = 30 + g;
    stp = 17 + g;
    rd  = 18 + g;
    w   = (n >= rd && n < fin) ? (n - rd) / 2 : -1;
    chk("crs", crs, (n == 7 || n == 15 || n == fin));
    chk("ip0", ip0, (n <= 5));
    chk("ip1", ip1, (n >= 8 && n <= 13));
    chk("brq", brq, (n >= 16 && n < fin));
    chk("erq", erq, (n >= stp && n < fin));
    chk("bis", bis, (n >= 16 && n < fin) ? bs : 2'b00);
    chk("eis", eis, (n >= 16 && n < fin) ? es : 2'b00);
    chk("xis", xis, (w >= 0 && w < 4) ? w : 0);
    chk("ris", ris, (w == 5));
    chk("busy", busy, (n < fin));
    chk("done", done, (n == fin));
  endtask

  task automatic chk_res();
    for (int i = 0; i < 8; i++) begin
      rsel = 3'(i);
      #1;
      chk($sformatf("res%0d", i), rdat, mres[i]);
    end
  endtask

  task automatic run(input int g, input int t, input int inj,
                     input bit normal, input int exp_n,
                     input bit exp_err);
    int n, d0, geff;
    geff = (g == 0) ? 1 : g;
    gate = GW'(g);
    tmo  = GW'(t);
    bsel = bs;
    esel = es;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    bsel = ~bs;
    esel = ~es;
    d0 = done_cnt;
    chk("err_clr", err, 1'b0);
    n = 0;
    while (done !== 1'b1 && n < 3000) begin
      if (normal) timeline(n, geff);
      start = (n == inj);
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    chk("latency", n, exp_n);
    if (normal) timeline(n, geff);
    chk("err", err, exp_err);
    @(negedge clk);
    chk("done_lo", done, 1'b0);
    chk("idle_crs", crs, 1'b1);
    chk("idle_bis", {bis, eis}, 4'h0);
    repeat (30) @(negedge clk);
    chk("ndone", done_cnt - d0, 1);
    chk("err_hold", err, exp_err);
    mres[0] = xoff;
    mres[1] = xoff;
    if (!exp_err) begin
      for (int i = 0; i < 4; i++) mres[2+i] = xoff + SIZE'(i);
      mres[6] = roff;
      mres[7] = roff + 1'b1;
    end
    chk_res();
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int g, t;
    rst = 1'b0; start = 1'b0; bsel = 0; esel = 0;
    gate = 0; tmo = 0; rsel = 0; bac = 1'b1; eac = 1'b1;
    xoff = 8'h10; roff = 8'h20; bs = 2'b01; es = 2'b10;
    for (int i = 0; i < 8; i++) mres[i] = '0;
    repeat (3) @(negedge clk);
    chk("rst_crs", crs, 1'b1);
    chk("rst_flags", {busy, done, err}, 3'b000);
    chk("rst_req", {brq, erq, ip0, ip1, ris}, 5'h0);
    chk("rst_sel", {bis, eis, xis}, 6'h0);
    chk("rst_sync", {dut.u_bac.q, dut.u_eac.q}, 2'b00);
    chk_res();
    rst = 1'b1;
    repeat (4) @(negedge clk);

    // reference run: offsets 0x10/0x20, gate 20
    run(20, 0, -1, 1'b1, 50, 1'b0);

    // stray start during C1
    xoff = 8'($urandom_range(0, 255));
    roff = 8'($urandom_range(0, 255));
    run(7, 0, 10, 1'b1, 37, 1'b0);

    // zero gate behaves as one
    run(0, 0, -1, 1'b1, 31, 1'b0);

    for (int k = 0; k < 4; k++) begin
      g = $urandom_range(0, 40);
      t = ($urandom_range(0, 1) != 0) ? $urandom_range(1, 1000) : 0;
      bs = 2'($urandom_range(0, 3));
      es = 2'($urandom_range(0, 3));
      xoff = 8'($urandom_range(0, 255));
      roff = 8'($urandom_range(0, 255));
      run(g, t, -1, 1'b1, ((g == 0) ? 1 : g) + 30, 1'b0);
    end

    // begin handshake never acknowledged
    bac = 1'b0;
    repeat (4) @(negedge clk);
    xoff = 8'($urandom_range(0, 255));
    run(12, 50, -1, 1'b0, 16 + 50, 1'b1);

    // end handshake never acknowledged
    bac = 1'b1;
    eac = 1'b0;
    repeat (4) @(negedge clk);
    g = $urandom_range(1, 30);
    t = $urandom_range(1, 30);
    xoff = 8'($urandom_range(0, 255));
    run(g, t, -1, 1'b0, 17 + g + t, 1'b1);
    eac = 1'b1;
    repeat (4) @(negedge clk);

    // recovery clears err
    xoff = 8'($urandom_range(0, 255));
    roff = 8'($urandom_range(0, 255));
    run(5, 0, -1, 1'b1, 35, 1'b0);

    // reset in the middle of GATE
    gate = 16'd50;
    tmo = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    chk("pre_gate", brq, 1'b1);
    rst = 1'b0;
    #1;
    chk("arst_busy", busy, 1'b0);
    chk("arst_crs", crs, 1'b1);
    repeat (3) @(negedge clk);
    chk("mrst_crs", crs, 1'b1);
    chk("mrst_brq", brq, 1'b0);
    chk("mrst_busy", busy, 1'b0);
    chk("mrst_done", done, 1'b0);
    for (int i = 0; i < 8; i++) mres[i] = '0;
    chk_res();
    rst = 1'b1;
    repeat (4) @(negedge clk);

    xoff = 8'($urandom_range(0, 255));
    roff = 8'($urandom_range(0, 255));
    run(3, 0, -1, 1'b1, 33, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
